// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 32;
  localparam int DEF_TIMEOUT = 16;

  // State encoding kept as plain constants so legacy code reading the state
  // register keeps working.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  // Index of the requester selected by a one-hot two-way grant.
  function automatic logic gnt_index(input logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: when both request, the one not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Purely combinational one-hot grant selection
  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single memory port with a timeout on
// the memory handshake. Outputs are decoded from registered state only.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_valid,
  input  logic                  m0_wr_rd,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0]      m0_wdata,
  output logic                  m0_ready,
  output logic [WIDTH-1:0]      m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_valid,
  input  logic                  m1_wr_rd,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0]      m1_wdata,
  output logic                  m1_ready,
  output logic [WIDTH-1:0]      m1_rdata,
  output logic                  m1_err,
  output logic                  mem_valid,
  output logic                  mem_wr_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]            state;
  logic                  last;
  logic                  gsel;
  logic [1:0]            gnt;
  logic                  lat_wr;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [WIDTH-1:0]      lat_wdata;
  logic [CW-1:0]         cnt;
  logic [WIDTH-1:0]      res_data;
  logic                  res_err;
  logic                  in_access;
  logic                  in_resp;

  rr_arb2 u_rr (
    .req  ({m1_valid, m0_valid}),
    .last (last),
    .gnt  (gnt)
  );

  // Main FSM: grant, memory access with timeout, one-cycle response
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      last      <= 1'b1;
      gsel      <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|gnt) begin
            gsel      <= gnt_index(gnt);
            lat_wr    <= gnt[1] ? m1_wr_rd : m0_wr_rd;
            lat_addr  <= gnt[1] ? m1_addr  : m0_addr;
            lat_wdata <= gnt[1] ? m1_wdata : m0_wdata;
            cnt       <= '0;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            res_data <= lat_wr ? '0 : mem_rdata;
            res_err  <= 1'b0;
            state    <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            res_data <= '0;
            res_err  <= 1'b1;
            state    <= S_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP: begin
          last  <= gsel;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_access = (state == S_ACCESS);
  assign in_resp   = (state == S_RESP);

  // Memory side is blanked outside ACCESS so nothing stale leaks out
  assign mem_valid = in_access;
  assign mem_wr_rd = in_access & lat_wr;
  assign mem_addr  = in_access ? lat_addr  : '0;
  assign mem_wdata = in_access ? lat_wdata : '0;

  assign m0_ready = in_resp & ~gsel;
  assign m1_ready = in_resp &  gsel;
  assign m0_rdata = m0_ready ? res_data : '0;
  assign m1_rdata = m1_ready ? res_data : '0;
  assign m0_err   = m0_ready & res_err;
  assign m1_err   = m1_ready & res_err;

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

  localparam int W  = 8;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_valid, m0_wr_rd, m1_valid, m1_wr_rd;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [W-1:0]  m0_wdata, m1_wdata;
  logic          m0_ready, m1_ready, m0_err, m1_err;
  logic [W-1:0]  m0_rdata, m1_rdata;
  logic          mem_valid, mem_wr_rd, mem_ready, busy;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_wr_rd(m0_wr_rd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_wr_rd(m1_wr_rd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int            m_who  = -1;  // requester being served, -1 when none
  bit            m_done = 0;   // response phase of the current transaction
  int            m_cycles;     // memory-access cycles spent so far
  int            m_last = 1;   // requester served most recently
  bit            t_wr;
  logic [AW-1:0] t_addr;
  logic [W-1:0]  t_wdata;
  logic [W-1:0]  r_data;
  bit            r_err;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_who = -1; m_done = 0; m_last = 1;
    end else if (m_who < 0) begin
      if (m0_valid || m1_valid) begin
        if (m0_valid && m1_valid) m_who = 1 - m_last;
        else                      m_who = m0_valid ? 0 : 1;
        t_wr    = (m_who == 0) ? m0_wr_rd : m1_wr_rd;
        t_addr  = (m_who == 0) ? m0_addr  : m1_addr;
        t_wdata = (m_who == 0) ? m0_wdata : m1_wdata;
        m_cycles = 0;
        m_done   = 0;
      end
    end else if (!m_done) begin
      m_cycles++;
      if (mem_ready) begin
        r_data = t_wr ? '0 : mem_rdata; r_err = 0; m_done = 1;
      end else if (m_cycles == TO) begin
        r_data = '0; r_err = 1; m_done = 1;
      end
    end else begin
      m_last = m_who; m_who = -1; m_done = 0;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial forever begin
    bit acc, rsp0, rsp1;
    @(negedge clk);
    if (chk_en) begin
      acc  = (m_who >= 0) && !m_done;
      rsp0 = (m_who == 0) && m_done;
      rsp1 = (m_who == 1) && m_done;
      chk("busy",      32'(busy),      32'(m_who >= 0));
      chk("mem_valid", 32'(mem_valid), 32'(acc));
      chk("mem_wr_rd", 32'(mem_wr_rd), 32'(acc && t_wr));
      chk("mem_addr",  32'(mem_addr),  acc ? 32'(t_addr)  : 32'd0);
      chk("mem_wdata", 32'(mem_wdata), acc ? 32'(t_wdata) : 32'd0);
      chk("m0_ready",  32'(m0_ready),  32'(rsp0));
      chk("m1_ready",  32'(m1_ready),  32'(rsp1));
      chk("m0_rdata",  32'(m0_rdata),  rsp0 ? 32'(r_data) : 32'd0);
      chk("m1_rdata",  32'(m1_rdata),  rsp1 ? 32'(r_data) : 32'd0);
      chk("m0_err",    32'(m0_err),    32'(rsp0 && r_err));
      chk("m1_err",    32'(m1_err),    32'(rsp1 && r_err));
    end
  end

  // ---------------- memory responder ----------------
  int           mem_mode  = 0;  // 0 fixed delay, 1 never ready, 2 random
  int           mem_delay = 0;
  logic [W-1:0] memarr [D];

  initial begin
    int  acc_cnt;
    int  cur_delay;
    bit  cur_never;
    acc_cnt = 0; cur_delay = 0; cur_never = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < D; i++) memarr[i] = W'($urandom);
    forever begin
      @(negedge clk);
      if (mem_valid === 1'b1) begin
        acc_cnt++;
        if (acc_cnt == 1) begin
          if (mem_mode == 2) begin
            cur_never = ($urandom % 8) == 0;
            cur_delay = int'($urandom % 5);
          end else begin
            cur_never = (mem_mode == 1);
            cur_delay = mem_delay;
          end
        end
        mem_ready = !cur_never && (acc_cnt > cur_delay);
        mem_rdata = memarr[mem_addr];
        if (mem_ready && mem_wr_rd) memarr[mem_addr] = mem_wdata;
      end else begin
        acc_cnt   = 0;
        mem_ready = (mem_mode == 2) ? 1'($urandom) : 1'b0;
        mem_rdata = W'($urandom);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_any(input int maxc, output int who, output int cyc);
    who = -1; cyc = 0;
    while (who < 0 && cyc < maxc) begin
      @(negedge clk); cyc++;
      if (m0_ready === 1'b1)      who = 0;
      else if (m1_ready === 1'b1) who = 1;
    end
    chk("ready_within_bound", 32'(who >= 0), 32'd1);
  endtask

  task automatic wait_mem_valid(input int maxc);
    int n;
    n = 0;
    while (mem_valid !== 1'b1 && n < maxc) begin
      @(negedge clk); n++;
    end
    chk("mem_valid_within_bound", 32'(mem_valid === 1'b1), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed then random stimulus ----------------
  initial begin
    int who, cyc, n, mv;
    int order [4];
    rst = 1'b1;
    m0_valid = 0; m0_wr_rd = 0; m0_addr = '0; m0_wdata = '0;
    m1_valid = 0; m1_wr_rd = 0; m1_addr = '0; m1_wdata = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_m0_ready",  32'(m0_ready),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // m0 write addr 10 data 100, memory ready on the third access cycle
    mem_mode = 0; mem_delay = 2;
    m0_valid = 1; m0_wr_rd = 1; m0_addr = 5'd10; m0_wdata = 8'd100;
    @(negedge clk);
    chk("t1_mem_addr",  32'(mem_addr),  32'd10);
    chk("t1_mem_wdata", 32'(mem_wdata), 32'd100);
    chk("t1_mem_wr_rd", 32'(mem_wr_rd), 32'd1);
    wait_any(40, who, cyc);
    chk("t1_who", 32'(who), 32'd0);
    chk("t1_err", 32'(m0_err), 32'd0);
    m0_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_m0_single_pulse", 32'(m0_ready), 32'd0);
    end

    // m1 reads back address 10
    mem_delay = 1;
    m1_valid = 1; m1_wr_rd = 0; m1_addr = 5'd10;
    wait_any(40, who, cyc);
    chk("t2_who",   32'(who),      32'd1);
    chk("t2_rdata", 32'(m1_rdata), 32'd100);
    chk("t2_m0_ready", 32'(m0_ready), 32'd0);
    m1_valid = 0;
    @(negedge clk);
    chk("t2_m1_single_pulse", 32'(m1_ready), 32'd0);

    // both held valid: grants must alternate starting with m0
    mem_delay = 0;
    m0_valid = 1; m0_wr_rd = 0; m0_addr = 5'd3;
    m1_valid = 1; m1_wr_rd = 0; m1_addr = 5'd4;
    for (int k = 0; k < 4; k++) begin
      wait_any(20, who, cyc);
      order[k] = who;
    end
    m0_valid = 0; m1_valid = 0;
    for (int k = 0; k < 4; k++) chk("t3_grant_order", 32'(order[k]), 32'(k % 2));
    @(negedge clk);

    // memory never answers: timeout after 16 access cycles
    mem_mode = 1;
    m0_valid = 1; m0_wr_rd = 0; m0_addr = 5'd7;
    wait_mem_valid(10);
    wait_any(40, who, cyc);
    chk("t4_timeout_latency", 32'(cyc), 32'd16);
    chk("t4_err",   32'(m0_err),   32'd1);
    chk("t4_rdata", 32'(m0_rdata), 32'd0);
    m0_valid = 0;
    @(negedge clk);
    chk("t4_busy_drop", 32'(busy), 32'd0);

    // reset pulsed mid-access abandons the transfer
    mem_mode = 0; mem_delay = 10;
    m0_valid = 1; m0_wr_rd = 1; m0_addr = 5'd9; m0_wdata = 8'd55;
    wait_mem_valid(10);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy",      32'(busy),      32'd0);
    chk("t5_mem_valid", 32'(mem_valid), 32'd0);
    chk("t5_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("t5_m0_ready",  32'(m0_ready),  32'd0);
    rst = 1'b0; mem_delay = 0;
    m1_valid = 1; m1_wr_rd = 0; m1_addr = 5'd2;
    wait_any(20, who, cyc);
    chk("t5_first_after_rst", 32'(who), 32'd0);
    m0_valid = 0;
    wait_any(20, who, cyc);
    chk("t5_second_after_rst", 32'(who), 32'd1);
    m1_valid = 0;
    @(negedge clk);

    // minimum latency with immediate memory ready
    m1_valid = 1; m1_wr_rd = 0; m1_addr = 5'd10;
    n = 0; mv = 0;
    while (m1_ready !== 1'b1 && n < 10) begin
      @(negedge clk); n++;
      mv += int'(mem_valid === 1'b1);
    end
    m1_valid = 0;
    chk("t6_edges_to_ready", 32'(n + 1), 32'd3);
    chk("t6_mem_valid_cycles", 32'(mv), 32'd1);
    @(negedge clk);

    // random traffic
    mem_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = (($urandom % 400) == 0);
      if (m0_valid && m0_ready) begin
        if ($urandom % 2) m0_valid = 0;
        else begin
          m0_wr_rd = 1'($urandom); m0_addr = AW'($urandom); m0_wdata = W'($urandom);
        end
      end else if (!m0_valid && ($urandom % 3) == 0) begin
        m0_valid = 1; m0_wr_rd = 1'($urandom); m0_addr = AW'($urandom); m0_wdata = W'($urandom);
      end
      if (m1_valid && m1_ready) begin
        if ($urandom % 2) m1_valid = 0;
        else begin
          m1_wr_rd = 1'($urandom); m1_addr = AW'($urandom); m1_wdata = W'($urandom);
        end
      end else if (!m1_valid && ($urandom % 3) == 0) begin
        m1_valid = 1; m1_wr_rd = 1'($urandom); m1_addr = AW'($urandom); m1_wdata = W'($urandom);
      end
    end
    @(negedge clk);
    rst = 1'b0; m0_valid = 0; m1_valid = 0;
    repeat (40) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, data width; DEPTH, default 32, memory words; ADDR_WIDTH, default $clog2(DEPTH), address width; TIMEOUT, default 16, max cycles waiting for mem_ready.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 m0_valid, m1_valid  input  1 each  requester n has a pending request.
REQ-005 m0_wr_rd, m1_wr_rd  input  1 each  1 = write, 0 = read.
REQ-006 m0_addr, m1_addr  input  ADDR_WIDTH each  request address.
REQ-007 m0_wdata, m1_wdata  input  WIDTH each  write data.
REQ-008 m0_ready, m1_ready  output  1 each  one-cycle completion strobe to requester n.
REQ-009 m0_rdata, m1_rdata  output  WIDTH each  read data, valid while mn_ready=1.
REQ-010 m0_err, m1_err  output  1 each  completion was a timeout, valid while mn_ready=1.
REQ-011 mem_valid, mem_wr_rd  output  1 each  request and direction to the memory.
REQ-012 mem_addr  output  ADDR_WIDTH; mem_wdata  output  WIDTH  request fields to the memory.
REQ-013 mem_rdata  input  WIDTH; mem_ready  input  1  memory read data and completion.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-016 In IDLE with at least one mn_valid=1, the arbiter SHALL grant one requester and enter ACCESS on the next edge.
- The granted requester's wr_rd, addr and wdata SHALL be latched on that same edge.
REQ-017 Round-robin arbitration:
- If only one requester is valid, it SHALL win.
- If both are valid, the requester not served last SHALL win.
- After reset, m0 SHALL have priority.
REQ-018 In ACCESS:
- mem_valid SHALL be 1 and driven with the latched fields, held stable until exit.
- An edge with mem_ready=1 SHALL capture mem_rdata (reads; zero for writes) and move to RESP.
REQ-019 A wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with mem_ready=0.
- When it reaches TIMEOUT-1 with mem_ready still 0, the FSM SHALL move to RESP with error set and rdata=0.
REQ-020 In RESP:
- The granted mn_ready SHALL be 1 for exactly one cycle, with mn_rdata and mn_err valid.
- mem_valid SHALL be 0.
- The last-served pointer SHALL update to the granted requester.
- The FSM SHALL return to IDLE.
REQ-021 Outside RESP, both mn_ready, mn_err and mn_rdata SHALL be 0; the non-granted requester SHALL never see ready.
REQ-022 A requester still valid during its RESP cycle SHALL be treated as a new request in the following IDLE, subject to round-robin.
REQ-023 Requests arriving during ACCESS/RESP SHALL wait without loss, since mn_valid is level-held by the requester.
REQ-024 Minimum latency, mn_valid sampled to mn_ready, SHALL be 3 edges when mem_ready=1 in the first ACCESS cycle.
REQ-025 All outputs SHALL be registered or decoded only from state; no combinational path from mn_* inputs to mem_* outputs.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, pointer=m1 (so m0 wins first), counter=0, latched fields=0.
- All outputs SHALL be 0 (mem_valid, mem_wr_rd, mem_addr, mem_wdata, mn_ready, mn_rdata, mn_err, busy).
REQ-027 Reset asserted mid-ACCESS or mid-RESP SHALL abandon the transfer without issuing any mn_ready.

Structure
REQ-028 A shared package mem_arb_pkg SHALL hold the state encoding (IDLE=0, ACCESS=1, RESP=2) and the default WIDTH, DEPTH and TIMEOUT constants.
REQ-029 The two-way round-robin picker SHALL be a sub-module rr_arb2.
- Inputs: req[1:0], last.
- Output: gnt (one-hot).
- It SHALL be purely combinational.

Verification
REQ-030 m0 write addr=10 wdata=100, mem_ready after 2 cycles -> mem_addr=10, mem_wdata=100, mem_wr_rd=1; m0_ready pulses once, m0_err=0.
REQ-031 m1 read addr=10 after REQ-030, memory returns 100 -> m1_ready one cycle with m1_rdata=100; m0_ready stays 0.
REQ-032 m0 and m1 valid simultaneously for 4 transactions -> grants m0, m1, m0, m1.
REQ-033 Memory never asserts ready, TIMEOUT=16 -> mn_ready with mn_err=1, rdata=0, 16 cycles after ACCESS entry; busy drops next cycle.
REQ-034 rst pulsed during ACCESS -> next cycle all outputs 0, no mn_ready; next request with both valid grants m0.
REQ-035 mem_ready=1 immediately -> mn_ready exactly 3 edges after mn_valid sampled; mem_valid high for exactly 1 cycle.
